rom_byte_loader: RTL and testbench

ROM_BYTE_LOADER -- requirements
Module: rom_byte_loader

---
 rtl/rom_loader_pkg.sv | 13 +
 rtl/rom_loader_fifo.sv | 45 ++++
 rtl/rom_byte_loader.sv | 157 +++++++++++++++
 tb/tb_rom_byte_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM byte loader: FSM state encoding and word geometry.
package rom_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_W         = 25;

endpackage

// File: rtl/rom_loader_fifo.sv
// Word FIFO between the host bridge and the byte serializer; same-cycle push/pop, synchronous flush.
module rom_loader_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/rom_byte_loader.sv
// Buffers 32-bit big-endian ROM words and replays them as paced ioctl byte writes.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to add a 16-bit running byte checksum output.
module rom_byte_loader
  import rom_loader_pkg::*;
#(
  parameter int WRITE_DELAY = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk_ppu_21_47,
  input  logic        reset,
  input  logic        bridge_start,
  input  logic        bridge_end,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        ioctl_download,
  output logic        ioctl_wr,
  output logic [7:0]  ioctl_dout,
  output logic [24:0] ioctl_addr,
  output logic        busy
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam logic [3:0] GAP      = 4'(WRITE_DELAY - 1);
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  loader_state_t state_q, state_d;

  logic        push, pop, fifo_empty, fifo_full;
  logic [31:0] fifo_dout;
  logic        emit_rdy, emit_shift, emit_pop, drain_done;

  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        left_q, left_d;
  logic [31:0]       shreg_q, shreg_d;
  logic              wr_q, wr_d;
  logic [7:0]        dout_q, dout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign push = word_valid && word_ready && !bridge_start;
  assign pop  = emit_pop && !bridge_start;

  rom_loader_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_ppu_21_47),
    .rst   (reset),
    .flush (bridge_start),
    .push  (push),
    .pop   (pop),
    .din   (word_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // cnt_q counts down the spacing since the last strobe; zero means a byte may go out now.
  assign emit_rdy   = (cnt_q == 4'd0);
  assign emit_shift = emit_rdy && (left_q != 2'd0);
  assign emit_pop   = emit_rdy && (left_q == 2'd0) && !fifo_empty;
  assign drain_done = fifo_empty && (left_q == 2'd0);

  always_ff @(posedge clk_ppu_21_47 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bridge_start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (bridge_end) state_d = DRAIN;
        DRAIN:   if (drain_done) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ioctl_download = (state_q == LOAD) || (state_q == DRAIN);
    busy           = (state_q != IDLE);
    word_ready     = (state_q == LOAD) && !fifo_full;
  end

  always_comb begin
    cnt_d   = cnt_q;
    left_d  = left_q;
    shreg_d = shreg_q;
    wr_d    = 1'b0;
    dout_d  = dout_q;
    addr_d  = wr_q ? addr_q + 25'd1 : addr_q;
    if (bridge_start) begin
      cnt_d  = 4'd0;
      left_d = 2'd0;
      addr_d = '0;
    end else if (emit_shift) begin
      wr_d    = 1'b1;
      dout_d  = shreg_q[31:24];
      shreg_d = {shreg_q[23:0], 8'h00};
      left_d  = left_q - 2'd1;
      cnt_d   = GAP;
    end else if (emit_pop) begin
      wr_d    = 1'b1;
      dout_d  = fifo_dout[31:24];
      shreg_d = {fifo_dout[23:0], 8'h00};
      left_d  = LAST_IDX;
      cnt_d   = GAP;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_ppu_21_47 or posedge reset) begin
    if (reset) begin
      cnt_q  <= 4'd0;
      left_q <= 2'd0;
      wr_q   <= 1'b0;
      dout_q <= 8'h00;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      left_q <= left_d;
      wr_q   <= wr_d;
      dout_q <= dout_d;
      addr_q <= addr_d;
    end
  end

  always_ff @(posedge clk_ppu_21_47) begin
    shreg_q <= shreg_d;
  end

  assign ioctl_wr   = wr_q;
  assign ioctl_dout = dout_q;
  assign ioctl_addr = addr_q;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (bridge_start) sum_d = 16'h0000;
    else if (wr_q)    sum_d = sum_q + {8'h00, dout_q};
  end

  always_ff @(posedge clk_ppu_21_47 or posedge reset) begin
    if (reset) sum_q <= 16'h0000;
    else       sum_q <= sum_d;
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_rom_byte_loader.sv
// Scoreboard bench for rom_byte_loader: expected bytes queued on word acceptance, checked on each strobe.
module tb_rom_byte_loader;

  localparam int WRITE_DELAY = 4;
  localparam int FIFO_DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        bridge_start;
  logic        bridge_end;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        busy;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  rom_byte_loader #(.WRITE_DELAY(WRITE_DELAY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_ppu_21_47  (clk),
    .reset          (reset),
    .bridge_start   (bridge_start),
    .bridge_end     (bridge_end),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .word_ready     (word_ready),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_addr     (ioctl_addr),
    .busy           (busy)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  d;
    logic [24:0] a;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_pulse = 0;
  int          last_pulse_cyc = -1;
  int          acc_cyc = 0;
  int          words_acc = 0;
  int          first_stall = -1;
  bit          gap_en = 1'b0;
  bit          have_held = 1'b0;
  logic [7:0]  held = 8'h00;
  logic [24:0] exp_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ioctl_wr) begin
      n_pulse++;
      check_eq("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_eq("wr_data", ioctl_dout, mon_e.d);
        check_eq("wr_addr", ioctl_addr, mon_e.a);
      end
      if (gap_en && last_pulse_cyc >= 0) check_eq("wr_gap", cyc - last_pulse_cyc, WRITE_DELAY);
      last_pulse_cyc = cyc;
      held = ioctl_dout;
      have_held = 1'b1;
    end else if (have_held) begin
      check_eq("dout_hold", ioctl_dout, held);
    end
  end

  task automatic pulse_start();
    bridge_start = 1'b1;
    @(posedge clk); #1;
    bridge_start = 1'b0;
    sb.delete();
    exp_addr = '0;
    last_pulse_cyc = -1;
    @(negedge clk);
    check_eq("dl_after_start", ioctl_download, 1);
    check_eq("ready_after_start", word_ready, 1);
    @(posedge clk); #1;
  endtask

  // Holds the word until accepted; leaves the bench at posedge+1 of the cycle after acceptance.
  task automatic send_word(input logic [31:0] w, input bit with_end);
    bit done = 1'b0;
    word_valid = 1'b1;
    word_data  = w;
    bridge_end = with_end;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (word_ready) begin
        done = 1'b1;
        acc_cyc = cyc;
        words_acc++;
        for (int b = 0; b < 4; b++) begin
          sb.push_back('{d: w[31-8*b -: 8], a: exp_addr});
          exp_addr++;
        end
      end else if (first_stall < 0) begin
        first_stall = words_acc;
      end
      @(posedge clk); #1;
      bridge_end = 1'b0;
    end
    word_valid = 1'b0;
    check_eq("word_accepted", done, 1);
  endtask

  task automatic wait_pulses(input int target, input string tag);
    for (int k = 0; k < 2000 && n_pulse < target; k++) begin
      @(negedge clk); #1;
    end
    check_eq(tag, n_pulse >= target, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 3000 && (ioctl_download || sb.size() != 0); k++) begin
      @(negedge clk); #1;
    end
    check_eq(tag, !ioctl_download && sb.size() == 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    int n1;
    reset = 1'b1; bridge_start = 1'b0; bridge_end = 1'b0;
    word_valid = 1'b0; word_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_download", ioctl_download, 0);
    check_eq("rst_wr", ioctl_wr, 0);
    check_eq("rst_dout", ioctl_dout, 0);
    check_eq("rst_addr", ioctl_addr, 0);
    check_eq("rst_ready", word_ready, 0);
    check_eq("rst_busy", busy, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    check_eq("rst_checksum", checksum, 0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_ready", word_ready, 0);

    // Single word with bridge_end on the same cycle.
    pulse_start();
    gap_en = 1'b1;
    n0 = n_pulse;
    send_word(32'h11223344, 1'b1);
    wait_pulses(n0 + 1, "first_wr_seen");
    check_eq("first_wr_latency", last_pulse_cyc - acc_cyc, 2);
    wait_pulses(n0 + 4, "last_wr_seen");
    check_eq("last_byte", ioctl_dout, 8'h44);
    check_eq("dl_at_last", ioctl_download, 1);
    @(negedge clk); #1;
    check_eq("dl_fall", ioctl_download, 0);
    check_eq("busy_fall", busy, 0);
    @(posedge clk); #1;

    // Ten back-to-back words against a small FIFO.
    pulse_start();
    gap_en = 1'b1;
    words_acc = 0;
    first_stall = -1;
    for (int i = 0; i < 10; i++) send_word($urandom, 1'b0);
    check_eq("words_before_stall", first_stall, FIFO_DEPTH + 1);
    bridge_end = 1'b1;
    @(posedge clk); #1;
    bridge_end = 1'b0;
    wait_idle("stream_done");

    // Restart mid-stream after six bytes.
    pulse_start();
    gap_en = 1'b0;
    n0 = n_pulse;
    for (int i = 0; i < 3; i++) send_word(32'hA0A1A2A3 + 32'h10101010 * i, 1'b0);
    wait_pulses(n0 + 6, "six_bytes_seen");
    @(posedge clk); #1;
    pulse_start();
    n1 = n_pulse;
    send_word(32'hDEADBEEF, 1'b1);
    wait_pulses(n1 + 1, "restart_wr_seen");
    check_eq("restart_addr", ioctl_addr, 0);
    check_eq("restart_data", ioctl_dout, 8'hDE);
    wait_idle("restart_done");

    // Address wrap at the top of the 25-bit space.
    pulse_start();
    gap_en = 1'b1;
    @(negedge clk);
    force dut.addr_q = 25'h1FFFFFE;
    @(negedge clk);
    release dut.addr_q;
    exp_addr = 25'h1FFFFFE;
    check_eq("addr_preset", ioctl_addr, 25'h1FFFFFE);
    @(posedge clk); #1;
    send_word(32'h55667788, 1'b1);
    wait_idle("wrap_done");

    // Reset while draining with three words still queued.
    pulse_start();
    gap_en = 1'b0;
    n0 = n_pulse;
    for (int i = 0; i < 4; i++) send_word(32'h01020304 * (i + 1), i == 3);
    wait_pulses(n0 + 1, "drain_first_wr");
    @(negedge clk); #2;
    check_eq("drain_download", ioctl_download, 1);
    check_eq("drain_ready", word_ready, 0);
    reset = 1'b1;
    #1;
    check_eq("arst_download", ioctl_download, 0);
    check_eq("arst_wr", ioctl_wr, 0);
    check_eq("arst_dout", ioctl_dout, 0);
    check_eq("arst_addr", ioctl_addr, 0);
    check_eq("arst_ready", word_ready, 0);
    check_eq("arst_busy", busy, 0);
    have_held = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n1 = n_pulse;
    repeat (40) @(negedge clk);
    #1;
    check_eq("no_wr_after_reset", n_pulse, n1);
    check_eq("idle_after_reset", busy, 0);
    @(posedge clk); #1;

`ifdef ROM_LOADER_CHECKSUM_EN
    pulse_start();
    gap_en = 1'b1;
    check_eq("checksum_cleared", checksum, 0);
    send_word(32'hFFFFFFFF, 1'b0);
    send_word(32'h01000000, 1'b1);
    wait_idle("checksum_done");
    check_eq("checksum", checksum, 16'h03FD);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
